// File: rtl/color_matrix_corrector.sv
// color_matrix_corrector
//   Applies a signed fixed-point CHANNELS x CHANNELS matrix and a per-channel
//   offset to every pixel of an AXI4-Stream video stream. Results are rounded
//   and saturated to PX_WIDTH. Coefficients are double-buffered: CSR writes go
//   to a shadow bank, and a commit copies shadow -> active at the next accepted
//   start-of-frame beat (tuser).
//
//   Ports
//     clk_i, rst_i          clock, asynchronous active-high reset
//     video_i_*             input stream  (tvalid/tready/tdata/tlast/tuser)
//     video_o_*             output stream (tvalid/tready/tdata/tlast/tuser)
//     coef_wr_i/addr/data   shadow-bank write port, entry = c*(CHANNELS+1)+k
//                           (k == CHANNELS selects the offset of channel c)
//     coef_commit_i         arms the shadow -> active copy
//     bypass_i              per-beat pass-through, same latency
//     coef_pending_o        a commit is armed but not yet applied

// One output channel: S1 products, S2 sum + offset + rounding, S3 shift/saturate.
module color_matrix_lane #(
    parameter int CHANNELS    = 3,
    parameter int PX_WIDTH    = 10,
    parameter int COEF_WIDTH  = 16,
    parameter int FRACT_WIDTH = 10,
    parameter int SUM_WIDTH   = 29
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                adv_i,
    input  logic [CHANNELS-1:0][PX_WIDTH-1:0]   px_i,
    input  logic [CHANNELS-1:0][COEF_WIDTH-1:0] coef_i,
    input  logic [PX_WIDTH:0]                   off_i,
    input  logic [PX_WIDTH-1:0]                 raw_i,
    input  logic                                byp_s2_i,
    output logic [PX_WIDTH-1:0]                 px_o
);
    localparam logic signed [SUM_WIDTH-1:0] ROUND  = SUM_WIDTH'(2 ** (FRACT_WIDTH - 1));
    localparam logic signed [SUM_WIDTH-1:0] PX_MAX = SUM_WIDTH'((2 ** PX_WIDTH) - 1);

    logic signed [SUM_WIDTH-1:0] prod_q [CHANNELS];
    logic signed [SUM_WIDTH-1:0] prod_d [CHANNELS];
    logic [PX_WIDTH:0]           off_q;
    logic [PX_WIDTH-1:0]         raw1_q, raw2_q;
    logic signed [SUM_WIDTH-1:0] sum_q, sum_d;
    logic signed [SUM_WIDTH-1:0] coef_x, px_x, shifted;
    logic [PX_WIDTH-1:0]         px_q, px_d;

    always_comb begin
        coef_x = '0;
        px_x   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            coef_x    = {{(SUM_WIDTH-COEF_WIDTH){coef_i[k][COEF_WIDTH-1]}}, coef_i[k]};
            px_x      = {{(SUM_WIDTH-PX_WIDTH){1'b0}}, px_i[k]};
            prod_d[k] = coef_x * px_x;
        end
    end

    // Offset is pre-scaled into the coefficient fraction domain before summing.
    always_comb begin
        sum_d = ({{(SUM_WIDTH-PX_WIDTH-1){off_q[PX_WIDTH]}}, off_q} << FRACT_WIDTH) + ROUND;
        for (int k = 0; k < CHANNELS; k++) begin
            sum_d = sum_d + prod_q[k];
        end
    end

    always_comb begin
        shifted = sum_q >>> FRACT_WIDTH;
        if (byp_s2_i)                       px_d = raw2_q;
        else if (shifted[SUM_WIDTH-1])      px_d = '0;
        else if (shifted > PX_MAX)          px_d = '1;
        else                                px_d = shifted[PX_WIDTH-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < CHANNELS; k++) prod_q[k] <= '0;
            off_q  <= '0;
            raw1_q <= '0;
            sum_q  <= '0;
            raw2_q <= '0;
            px_q   <= '0;
        end else if (adv_i) begin
            for (int k = 0; k < CHANNELS; k++) prod_q[k] <= prod_d[k];
            off_q  <= off_i;
            raw1_q <= raw_i;
            sum_q  <= sum_d;
            raw2_q <= raw1_q;
            px_q   <= px_d;
        end
    end

    assign px_o = px_q;
endmodule

module color_matrix_corrector #(
    parameter int CHANNELS    = 3,
    parameter int PX_WIDTH    = 10,
    parameter int TDATA_WIDTH = 32,
    parameter int COEF_WIDTH  = 16,
    parameter int FRACT_WIDTH = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   video_i_tvalid,
    output logic                   video_i_tready,
    input  logic [TDATA_WIDTH-1:0] video_i_tdata,
    input  logic                   video_i_tlast,
    input  logic                   video_i_tuser,
    output logic                   video_o_tvalid,
    input  logic                   video_o_tready,
    output logic [TDATA_WIDTH-1:0] video_o_tdata,
    output logic                   video_o_tlast,
    output logic                   video_o_tuser,
    input  logic                   coef_wr_i,
    input  logic [7:0]             coef_addr_i,
    input  logic [COEF_WIDTH-1:0]  coef_data_i,
    input  logic                   coef_commit_i,
    input  logic                   bypass_i,
    output logic                   coef_pending_o
);
    localparam int STAGES    = 3;
    localparam int NUM_ENT   = CHANNELS * (CHANNELS + 1);
    localparam int AW        = (NUM_ENT > 1) ? $clog2(NUM_ENT) : 1;
    localparam int SUM_WIDTH = COEF_WIDTH + PX_WIDTH + 1 + $clog2(CHANNELS);
    localparam int PXW_ALL   = CHANNELS * PX_WIDTH;

    function automatic logic [COEF_WIDTH-1:0] ident(input int i);
        return ((i % (CHANNELS + 1)) == (i / (CHANNELS + 1))) ? COEF_WIDTH'(1 << FRACT_WIDTH) : '0;
    endfunction

    logic [COEF_WIDTH-1:0] shadow_q [NUM_ENT];
    logic [COEF_WIDTH-1:0] active_q [NUM_ENT];
    logic [COEF_WIDTH-1:0] bank_sel [NUM_ENT];
    logic                  pending_q;

    logic [STAGES:1] vld_q, last_q, user_q, byp_q;
    logic            adv, acc, swap, wr_ok;
    logic [AW-1:0]   wr_idx;

    logic [CHANNELS-1:0][PX_WIDTH-1:0]                 px_in, px_out;
    logic [CHANNELS-1:0][CHANNELS-1:0][COEF_WIDTH-1:0] coef_row;
    logic [CHANNELS-1:0][PX_WIDTH:0]                   off_row;

    // Global stall: every stage moves together whenever the output is free.
    assign adv            = !vld_q[STAGES] || video_o_tready;
    assign acc            = video_i_tvalid && adv;
    assign swap           = pending_q && acc && video_i_tuser;
    assign video_i_tready = adv;
    assign wr_ok          = coef_wr_i && (coef_addr_i < 8'(NUM_ENT));
    assign wr_idx         = coef_addr_i[AW-1:0];

    // The frame-start beat that triggers the copy must already see the new
    // coefficients, so S1 reads the shadow bank directly on that beat.
    always_comb begin
        for (int i = 0; i < NUM_ENT; i++) begin
            bank_sel[i] = swap ? shadow_q[i] : active_q[i];
        end
    end

    // Copy reads shadow_q before this cycle's write lands; a commit in the same
    // cycle as the copy re-arms for the following frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                shadow_q[i] <= ident(i);
                active_q[i] <= ident(i);
            end
            pending_q <= 1'b0;
        end else begin
            if (swap) begin
                for (int i = 0; i < NUM_ENT; i++) active_q[i] <= shadow_q[i];
            end
            if (wr_ok) shadow_q[wr_idx] <= coef_data_i;
            if (coef_commit_i)  pending_q <= 1'b1;
            else if (swap)      pending_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= '0;
            last_q <= '0;
            user_q <= '0;
            byp_q  <= '0;
        end else if (adv) begin
            vld_q  <= {vld_q[STAGES-1:1],  video_i_tvalid};
            last_q <= {last_q[STAGES-1:1], video_i_tlast};
            user_q <= {user_q[STAGES-1:1], video_i_tuser};
            byp_q  <= {byp_q[STAGES-1:1],  bypass_i};
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        assign px_in[c]   = video_i_tdata[c*PX_WIDTH +: PX_WIDTH];
        assign off_row[c] = bank_sel[c*(CHANNELS+1)+CHANNELS][PX_WIDTH:0];
        for (genvar k = 0; k < CHANNELS; k++) begin : g_coef
            assign coef_row[c][k] = bank_sel[c*(CHANNELS+1)+k];
        end
        if (COEF_WIDTH > PX_WIDTH + 1) begin : g_unused_off
            logic unused_off;
            assign unused_off = ^bank_sel[c*(CHANNELS+1)+CHANNELS][COEF_WIDTH-1:PX_WIDTH+1];
        end

        color_matrix_lane #(
            .CHANNELS   (CHANNELS),
            .PX_WIDTH   (PX_WIDTH),
            .COEF_WIDTH (COEF_WIDTH),
            .FRACT_WIDTH(FRACT_WIDTH),
            .SUM_WIDTH  (SUM_WIDTH)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .adv_i   (adv),
            .px_i    (px_in),
            .coef_i  (coef_row[c]),
            .off_i   (off_row[c]),
            .raw_i   (px_in[c]),
            .byp_s2_i(byp_q[2]),
            .px_o    (px_out[c])
        );
    end

    if (TDATA_WIDTH > PXW_ALL) begin : g_unused_tdata
        logic unused_tdata;
        assign unused_tdata = ^video_i_tdata[TDATA_WIDTH-1:PXW_ALL];
    end

    always_comb begin
        video_o_tdata = '0;
        video_o_tdata[PXW_ALL-1:0] = px_out;
    end

    assign video_o_tvalid = vld_q[STAGES];
    assign video_o_tlast  = last_q[STAGES];
    assign video_o_tuser  = user_q[STAGES];
    assign coef_pending_o = pending_q;
endmodule

// File: tb/tb_color_matrix_corrector.sv
module tb_color_matrix_corrector;
    localparam int C = 3, PW = 10, TW = 32, CW = 16, NE = 12;

    typedef struct {
        logic [TW-1:0] data;
        logic          last;
        logic          user;
    } exp_t;

    logic          clk = 1'b0, rst = 1'b0;
    logic          i_tvalid = 1'b0, i_tready, i_tlast = 1'b0, i_tuser = 1'b0;
    logic [TW-1:0] i_tdata = '0;
    logic          o_tvalid, o_tready = 1'b1, o_tlast, o_tuser;
    logic [TW-1:0] o_tdata;
    logic          coef_wr = 1'b0, coef_commit = 1'b0, byp = 1'b0, pending;
    logic [7:0]    coef_addr = '0;
    logic [CW-1:0] coef_data = '0;

    int   total = 0, bad = 0;
    bit   bp_en = 1'b0;
    bit   ovr_en = 1'b0;
    logic [TW-1:0] ovr_data = '0;
    exp_t exp_q[$];

    // Reference state: two banks and the pending flag, as the behaviour is described.
    logic [CW-1:0] sh_m [NE];
    logic [CW-1:0] ac_m [NE];
    bit            pend_m;

    always #5 clk = ~clk;

    color_matrix_corrector dut (
        .clk_i(clk), .rst_i(rst),
        .video_i_tvalid(i_tvalid), .video_i_tready(i_tready), .video_i_tdata(i_tdata),
        .video_i_tlast(i_tlast), .video_i_tuser(i_tuser),
        .video_o_tvalid(o_tvalid), .video_o_tready(o_tready), .video_o_tdata(o_tdata),
        .video_o_tlast(o_tlast), .video_o_tuser(o_tuser),
        .coef_wr_i(coef_wr), .coef_addr_i(coef_addr), .coef_data_i(coef_data),
        .coef_commit_i(coef_commit), .bypass_i(byp), .coef_pending_o(pending)
    );

    function automatic logic [TW-1:0] mk(input int p0, input int p1, input int p2);
        logic [TW-1:0] r;
        r = '0;
        r[9:0] = 10'(p0); r[19:10] = 10'(p1); r[29:20] = 10'(p2);
        return r;
    endfunction

    // out_c = clamp(floor((sum coef*in + off*1024 + 512) / 1024)), offsets 11-bit signed.
    function automatic logic [TW-1:0] ref_data(input logic [TW-1:0] din, input bit b,
                                               input logic [CW-1:0] m [NE]);
        logic [TW-1:0] r;
        longint s, q;
        r = '0;
        for (int c = 0; c < C; c++) begin
            if (b) begin
                q = longint'(din[c*PW +: PW]);
            end else begin
                s = 0;
                for (int k = 0; k < C; k++)
                    s += longint'($signed(m[c*4+k])) * longint'(din[k*PW +: PW]);
                s += longint'($signed(m[c*4+3][10:0])) * 1024 + 512;
                q = s / 1024;
                if (s < 0 && (s % 1024) != 0) q = q - 1;
                if (q < 0) q = 0;
                if (q > 1023) q = 1023;
            end
            r[c*PW +: PW] = 10'(q);
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            sh_m[i] = ((i % 4) == (i / 4)) ? 16'd1024 : 16'd0;
            ac_m[i] = sh_m[i];
        end
        pend_m = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    // Effect of one clock edge on the reference, evaluated with pre-edge inputs.
    task automatic model_edge(input bit acc);
        exp_t e;
        if (acc) begin
            if (i_tuser && pend_m) begin
                ac_m   = sh_m;
                pend_m = 1'b0;
            end
            e.data = ovr_en ? ovr_data : ref_data(i_tdata, byp, ac_m);
            e.last = i_tlast;
            e.user = i_tuser;
            exp_q.push_back(e);
        end
        if (coef_commit) pend_m = 1'b1;
        if (coef_wr && coef_addr < 8'(NE)) sh_m[coef_addr[3:0]] = coef_data;
    endtask

    task automatic tick(output bit acc);
        @(negedge clk);
        acc = i_tvalid && i_tready;
        @(posedge clk);
        model_edge(acc);
        #1;
        coef_wr     = 1'b0;
        coef_commit = 1'b0;
        if (!rst) chk("pending_track", 32'(pending), 32'(pend_m));
    endtask

    task automatic beat(input int p0, input int p1, input int p2, input bit u, input bit l, input bit b);
        bit done;
        int n;
        done = 1'b0; n = 0;
        i_tvalid = 1'b1; i_tdata = mk(p0, p1, p2); i_tuser = u; i_tlast = l; byp = b;
        while (!done) begin
            tick(done);
            n++;
            if (!done && n > 1000) begin
                total++; bad++;
                $display("FAIL beat_timeout waited=%0d cycles want=accept", n);
                break;
            end
        end
        i_tvalid = 1'b0; ovr_en = 1'b0;
    endtask

    task automatic obeat(input int p0, input int p1, input int p2, input bit u, input bit l,
                         input logic [TW-1:0] want);
        ovr_en = 1'b1; ovr_data = want;
        beat(p0, p1, p2, u, l, 1'b0);
    endtask

    task automatic wr(input int a, input int d);
        bit dmy;
        coef_wr = 1'b1; coef_addr = 8'(a); coef_data = 16'(d);
        tick(dmy);
    endtask

    task automatic load(input int m [9], input int off [3], input bit commit);
        bit dmy;
        for (int c = 0; c < C; c++) begin
            for (int k = 0; k < C; k++) wr(c*4+k, m[c*3+k]);
            wr(c*4+3, off[c]);
        end
        if (commit) begin
            coef_commit = 1'b1;
            tick(dmy);
        end
    endtask

    task automatic drain();
        bit dmy;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            tick(dmy);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout left=%0d want=0", exp_q.size());
        end
    endtask

    always @(posedge clk) begin
        #1;
        o_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pop on every output handshake; also hold-while-stalled check.
    bit            stall_prev = 1'b0;
    logic [TW-1:0] st_data;
    logic          st_last, st_user;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                total++;
                if (!(o_tvalid === 1'b1 && o_tdata === st_data && o_tlast === st_last && o_tuser === st_user)) begin
                    bad++;
                    $display("FAIL stall_hold got v=%b d=%h l=%b u=%b want v=1 d=%h l=%b u=%b",
                             o_tvalid, o_tdata, o_tlast, o_tuser, st_data, st_last, st_user);
                end
            end
            if (o_tvalid && o_tready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL out_unexpected got d=%h want=no beat", o_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if (o_tdata !== e.data || o_tlast !== e.last || o_tuser !== e.user) begin
                        bad++;
                        $display("FAIL out_beat got d=%h l=%b u=%b want d=%h l=%b u=%b",
                                 o_tdata, o_tlast, o_tuser, e.data, e.last, e.user);
                    end
                end
            end
            stall_prev = o_tvalid && !o_tready;
            st_data = o_tdata; st_last = o_tlast; st_user = o_tuser;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int id [9]  = '{1024,0,0, 0,1024,0, 0,0,1024};
        int sw [9]  = '{0,0,1024, 0,1024,0, 1024,0,0};
        int d15 [9] = '{1536,0,0, 0,1536,0, 0,0,1536};
        int z [3]   = '{0,0,0};
        int rm [9];
        int ro [3];

        model_reset();
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_tvalid", 32'(o_tvalid), 0);
        chk("rst_tdata", o_tdata, 0);
        chk("rst_tlast", 32'(o_tlast), 0);
        chk("rst_tuser", 32'(o_tuser), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_i_tready", 32'(i_tready), 1);
        @(posedge clk); #1 rst = 1'b0;

        // Identity, latency of exactly 3 cycles, upper tdata bits zero.
        obeat(100, 200, 300, 1, 0, mk(100, 200, 300));
        @(negedge clk); chk("lat_cycle1", 32'(o_tvalid), 0);
        @(negedge clk); chk("lat_cycle2", 32'(o_tvalid), 0);
        @(negedge clk); chk("lat_cycle3", 32'(o_tvalid), 1);
        chk("upper_bits", 32'(o_tdata[31:30]), 0);
        @(posedge clk); #1;

        // Rounding of 1.5 up to 2 and clamp at 1023.
        load(d15, z, 1);
        chk("pend_after_commit", 32'(pending), 1);
        obeat(1000, 1, 0, 1, 0, mk(1023, 2, 0));
        chk("pend_after_sof", 32'(pending), 0);

        // Negative offset clamps to zero.
        load(id, '{-50, 0, 0}, 1);
        obeat(30, 40, 50, 1, 0, mk(0, 40, 50));

        // Mid-frame commit only takes effect at the next frame start.
        load(id, z, 1);
        obeat(1, 2, 3, 1, 0, mk(1, 2, 3));
        obeat(10, 20, 30, 0, 0, mk(10, 20, 30));
        load(sw, z, 1);
        obeat(11, 22, 33, 0, 1, mk(11, 22, 33));
        chk("pend_mid_frame", 32'(pending), 1);
        obeat(7, 8, 9, 1, 0, mk(9, 8, 7));
        chk("pend_swap_done", 32'(pending), 0);

        // Commit coincident with a tuser handshake waits for the next frame.
        load(id, z, 0);
        coef_commit = 1'b1;
        obeat(4, 5, 6, 1, 0, mk(6, 5, 4));
        chk("pend_commit_sof", 32'(pending), 1);
        obeat(1, 2, 3, 0, 1, mk(3, 2, 1));
        chk("pend_held", 32'(pending), 1);
        obeat(1, 2, 3, 1, 0, mk(1, 2, 3));
        chk("pend_applied", 32'(pending), 0);
        drain();

        // Random pixels, random backpressure, random CSR traffic.
        bp_en = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            bit dmy;
            if ($urandom_range(0, 3) == 0) tick(dmy);
            if ($urandom_range(0, 15) == 0) begin
                coef_wr   = 1'b1;
                coef_addr = 8'($urandom_range(0, 15));
                coef_data = (coef_addr[1:0] == 2'd3) ? 16'(int'($urandom_range(0, 511)) - 256)
                                                     : 16'(int'($urandom_range(0, 4095)) - 2048);
            end
            if ($urandom_range(0, 63) == 0) coef_commit = 1'b1;
            beat($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023),
                 (n % 20) == 0, (n % 20) == 19, $urandom_range(0, 3) == 0);
        end
        bp_en = 1'b0;
        drain();

        // Bypass toggled per pixel, then reset while beats are in flight.
        for (int i = 0; i < 9; i++) rm[i] = int'($urandom_range(0, 2047)) - 1024;
        for (int i = 0; i < 3; i++) ro[i] = int'($urandom_range(0, 200)) - 100;
        load(rm, ro, 1);
        beat(500, 600, 700, 1, 0, 0);
        load(sw, ro, 1);
        for (int i = 0; i < 6; i++) begin
            int a, b, c;
            a = $urandom_range(0, 1023); b = $urandom_range(0, 1023); c = $urandom_range(0, 1023);
            if (i % 2 == 0) begin
                ovr_en = 1'b1; ovr_data = mk(a, b, c);
            end
            beat(a, b, c, 0, 0, (i % 2) == 0);
        end
        chk("pend_before_rst", 32'(pending), 1);
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        @(negedge clk);
        chk("midrst_tvalid", 32'(o_tvalid), 0);
        chk("midrst_tdata", o_tdata, 0);
        chk("midrst_pending", 32'(pending), 0);
        chk("midrst_i_tready", 32'(i_tready), 1);
        @(posedge clk); #1 rst = 1'b0;
        byp = 1'b0;
        obeat(5, 6, 7, 1, 0, mk(5, 6, 7));
        coef_commit = 1'b1;
        obeat(8, 9, 10, 0, 0, mk(8, 9, 10));
        obeat(11, 12, 13, 1, 1, mk(11, 12, 13));
        chk("pend_after_rst_sof", 32'(pending), 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
